// File: rtl/servo_link_pkg.sv
// rtl/servo_link_pkg.sv - shared constants for the servo status serial link
// Purpose: FSM state encodings, default word width and bit divider, line idle level.
// Ports: none (package).
package servo_link_pkg;

    localparam int SERVO_WORD_W    = 16;
    localparam int BIT_DIV_DEFAULT = 104;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period tick generator for the servo serial link
// Purpose: counts 0..BIT_DIV-1 and flags the last cycle of each line bit.
// Ports:
//   mclk  in   system clock
//   rst   in   asynchronous reset, active-high
//   clr   in   restart the bit period (counter back to 0 next cycle)
//   tick  out  high on the final cycle of a bit period (count == BIT_DIV-1)
module baud_tick_gen #(
    parameter int BIT_DIV = 104
) (
    input  logic mclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = 12;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(BIT_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_frame_tx.sv
// rtl/servo_frame_tx.sv - UART-style serialiser for the 16-bit servo status word
// Purpose: one-entry holding register feeding a START/DATA/(PARITY)/STOP shifter.
//   Optional even parity bit is built when the macro PARITY_EN is defined.
// Ports:
//   mclk         in   system clock, all logic on posedge
//   rst          in   asynchronous reset, active-high
//   data_in      in   status word, captured on data_valid & ready
//   data_valid   in   one-cycle strobe
//   ready        out  holding register empty
//   tx           out  serial line, idles high
//   busy         out  shifter active (START through end of STOP)
//   overflow     out  sticky: strobe seen while holding register full
//   frame_count  out  completed frames, wraps at 256
module servo_frame_tx
    import servo_link_pkg::*;
#(
    parameter int WIDTH   = SERVO_WORD_W,
    parameter int BIT_DIV = BIT_DIV_DEFAULT
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             overflow,
    output logic [7:0]       frame_count
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             load;
    logic             tick;
`ifdef PARITY_EN
    logic             parity_q, parity_d;
`endif

    baud_tick_gen #(
        .BIT_DIV (BIT_DIV)
    ) u_baud (
        .mclk (mclk),
        .rst  (rst),
        .clr  (load),
        .tick (tick)
    );

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        hold_data_d   = hold_data_q;
        hold_full_d   = hold_full_q;
        overflow_d    = overflow_q;
        frame_count_d = frame_count_q;
        load          = 1'b0;
`ifdef PARITY_EN
        parity_d      = parity_q;
`endif

        // A full holding register is never overwritten; the late word is dropped.
        if (data_valid) begin
            if (hold_full_q) begin
                overflow_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_data_d = data_in;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = IDX_W'(WIDTH - 1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == '0) begin
`ifdef PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                        shift_d   = shift_q << 1;
                    end
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    frame_count_d = frame_count_q + 8'd1;
                    // Back-to-back frames: go straight to START with no idle bit.
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // load and a new capture are exclusive: capture needs empty, load needs full.
        if (load) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
            state_d     = ST_START;
`ifdef PARITY_EN
            parity_d    = ^hold_data_q;
`endif
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            hold_data_q   <= '0;
            hold_full_q   <= 1'b0;
            overflow_q    <= 1'b0;
            frame_count_q <= 8'd0;
`ifdef PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            hold_data_q   <= hold_data_d;
            hold_full_q   <= hold_full_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
`ifdef PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    // Line level decoded straight from registered state so reset forces idle at once.
    always_comb begin
        tx = IDLE_LEVEL;
        case (state_q)
            ST_START: tx = ~IDLE_LEVEL;
            ST_DATA:  tx = shift_q[WIDTH-1];
`ifdef PARITY_EN
            ST_PARITY: tx = parity_q;
`endif
            default:  tx = IDLE_LEVEL;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign ready       = ~hold_full_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_servo_frame_tx.sv
// tb/tb_servo_frame_tx.sv - scoreboard bench for servo_frame_tx with BIT_DIV=4
module tb_servo_frame_tx;

    localparam int BD = 4;
`ifdef PARITY_EN
    localparam int NB = 19;
`else
    localparam int NB = 18;
`endif
    localparam int FRAME = NB * BD;

    typedef struct packed {
        logic [15:0] data;
        logic        par;
        logic        no_gap;
    } exp_t;

    logic        mclk;
    logic        rst;
    logic [15:0] data_in;
    logic        data_valid;
    logic        ready;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [7:0]  frame_count;

    int   total;
    int   bad;
    exp_t exp_q[$];
    bit   mon_busy;

    servo_frame_tx #(
        .WIDTH   (16),
        .BIT_DIV (BD)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .ready       (ready),
        .tx          (tx),
        .busy        (busy),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        @(posedge mclk);
        #1;
        data_in    = w;
        data_valid = 1'b1;
        @(posedge mclk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [15:0] w, input logic p, input logic ng);
        exp_t e;
        e.data   = w;
        e.par    = p;
        e.no_gap = ng;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy || busy) && n < 2000) begin
            @(posedge mclk);
            #1;
            n++;
        end
        check(name, (n < 2000), 1);
    endtask

    // Monitor: decodes frames on tx, checks every bit holds for BD cycles.
    initial begin : monitor
        int          cyc;
        int          start_cyc;
        int          last_end;
        bit          abort;
        bit          unstable;
        logic [18:0] bitv;
        logic [15:0] word;
        exp_t        e;
        cyc      = 0;
        last_end = -100;
        mon_busy = 1'b0;
        forever begin
            @(negedge mclk);
            cyc++;
            if (rst === 1'b0 && tx === 1'b0) begin
                mon_busy  = 1'b1;
                abort     = 1'b0;
                unstable  = 1'b0;
                bitv      = '0;
                start_cyc = cyc;
                for (int b = 0; b < NB && !abort; b++) begin
                    for (int s = 0; s < BD && !abort; s++) begin
                        if (!(b == 0 && s == 0)) begin
                            @(negedge mclk);
                            cyc++;
                        end
                        if (rst !== 1'b0) begin
                            abort = 1'b1;
                        end else if (s == 0) begin
                            bitv[b] = tx;
                        end else if (tx !== bitv[b]) begin
                            unstable = 1'b1;
                        end
                    end
                end
                if (!abort) begin
                    for (int i = 0; i < 16; i++) word[15-i] = bitv[1+i];
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {16'h0, word}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", {16'h0, word}, {16'h0, e.data});
                        check("bit_width", {31'h0, unstable}, 0);
                        check("stop_bit", {31'h0, bitv[NB-1]}, 1);
`ifdef PARITY_EN
                        check("parity_bit", {31'h0, bitv[17]}, {31'h0, e.par});
`endif
                        if (e.no_gap) begin
                            check("idle_gap", start_cyc - last_end - 1, 0);
                        end
                    end
                    last_end = cyc;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        data_in    = 16'h0;
        data_valid = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        rst = 1'b0;

        // T1: quiet after reset
        repeat (100) @(posedge mclk);
        #1;
        check("t1_tx", {31'h0, tx}, 1);
        check("t1_busy", {31'h0, busy}, 0);
        check("t1_ready", {31'h0, ready}, 1);
        check("t1_count", {24'h0, frame_count}, 0);
        check("t1_overflow", {31'h0, overflow}, 0);

        // T2: 4A25, load latency and frame length
        begin
            int n;
            expect_frame(16'h4A25, 1'b0, 1'b0);
            send(16'h4A25);
            check("t2_ready_low", {31'h0, ready}, 0);
            check("t2_tx_idle", {31'h0, tx}, 1);
            check("t2_not_busy", {31'h0, busy}, 0);
            @(posedge mclk);
            #1;
            check("t2_start_tx", {31'h0, tx}, 0);
            check("t2_start_busy", {31'h0, busy}, 1);
            check("t2_ready_back", {31'h0, ready}, 1);
            n = 1;
            while (busy && n < 200) begin
                @(posedge mclk);
                #1;
                if (busy) n++;
            end
            check("t2_frame_len", n, FRAME);
            wait_idle("t2_done");
            check("t2_count", {24'h0, frame_count}, 1);
        end

        // T3: single set LSB (odd parity input)
        expect_frame(16'h0001, 1'b1, 1'b0);
        send(16'h0001);
        wait_idle("t3_done");
        check("t3_count", {24'h0, frame_count}, 2);

        // T4: second word queued mid-frame follows with no idle gap
        expect_frame(16'hFFFF, 1'b0, 1'b0);
        expect_frame(16'h1234, 1'b1, 1'b1);
        send(16'hFFFF);
        @(posedge mclk);
        #1;
        repeat (5) @(posedge mclk);
        #1;
        send(16'h1234);
        check("t4_ready_held", {31'h0, ready}, 0);
        repeat (FRAME - 9) @(posedge mclk);
        #1;
        check("t4_ready_late", {31'h0, ready}, 0);
        repeat (2) @(posedge mclk);
        #1;
        check("t4_next_start", {31'h0, tx}, 0);
        check("t4_ready_after_load", {31'h0, ready}, 1);
        check("t4_busy", {31'h0, busy}, 1);
        wait_idle("t4_done");
        check("t4_count", {24'h0, frame_count}, 4);
        check("t4_no_overflow", {31'h0, overflow}, 0);

        // T5: third word while holding full is dropped
        expect_frame(16'h00FF, 1'b0, 1'b0);
        expect_frame(16'h8001, 1'b0, 1'b1);
        send(16'h00FF);
        repeat (2) @(posedge mclk);
        send(16'h8001);
        send(16'h7777);
        check("t5_overflow", {31'h0, overflow}, 1);
        check("t5_ready", {31'h0, ready}, 0);
        wait_idle("t5_done");
        check("t5_count", {24'h0, frame_count}, 6);
        check("t5_overflow_sticky", {31'h0, overflow}, 1);

        // T6: reset during DATA bit 7
        send(16'h1111);
        @(posedge mclk);
        #1;
        repeat (37) @(posedge mclk);
        #1;
        check("t6_mid_bit7", {31'h0, tx}, 0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_tx_abort", {31'h0, tx}, 1);
        check("t6_busy_abort", {31'h0, busy}, 0);
        check("t6_ready_abort", {31'h0, ready}, 1);
        repeat (3) @(posedge mclk);
        #1;
        rst = 1'b0;
        check("t6_count_clr", {24'h0, frame_count}, 0);
        check("t6_overflow_clr", {31'h0, overflow}, 0);
        expect_frame(16'hA5A5, 1'b0, 1'b0);
        send(16'hA5A5);
        wait_idle("t6_done");
        check("t6_count", {24'h0, frame_count}, 1);

        repeat (10) @(posedge mclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
